operand_fetch_stage: RTL and testbench
======================================

// Module: operand_fetch_stage
// PURPOSE
//  Issue/operand-fetch stage sitting directly upstream of register_file: drives its two read
//  ports, snoops its write port (writeback) and registers the operands for the execute stage.
//  Holds a per-register scoreboard of pending writes. Stalls RAW/WAW hazards and bypasses
//  same-cycle writeback data. One output pipeline register with valid/ready on both sides.
// PARAMETERS
//  REG_W      32  register / operand width
//  REG_COUNT  32  architectural registers; index width REG_IDX_W = $clog2(REG_COUNT)
//  PAYLOAD_W  32  opaque side-band passed through unchanged (pc, opcode, ...)
// PORTS
//  clk          in   1           clock, all state updates on posedge
//  aresetn      in   1           asynchronous active-low reset
//  flush        in   1           kill instruction in output register, block issue this cycle
//  in_valid     in   1           decoded instruction present
//  in_ready     out  1           stage accepts instruction this cycle
//  in_rs1       in   REG_IDX_W   source register 1
//  in_rs2       in   REG_IDX_W   source register 2
//  in_rd        in   REG_IDX_W   destination register
//  in_rd_wen    in   1           instruction writes in_rd
//  in_payload   in   PAYLOAD_W   pass-through side-band
//  rf_rd_reg_a  out  REG_IDX_W   to register_file.rd_reg_a (= in_rs1, combinational)
//  rf_rd_reg_b  out  REG_IDX_W   to register_file.rd_reg_b (= in_rs2, combinational)
//  rf_rd_data_a in   REG_W       from register_file.rd_data_a (combinational read)
//  rf_rd_data_b in   REG_W       from register_file.rd_data_b
//  wb_en        in   1           writeback enable (same signal as register_file.wr_en)
//  wb_reg       in   REG_IDX_W   writeback register (= register_file.wr_reg)
//  wb_data      in   REG_W       writeback data (= register_file.wr_data)
//  out_valid    out  1           operands valid to execute
//  out_ready    in   1           execute accepts
//  out_rs1_data out  REG_W       operand 1
//  out_rs2_data out  REG_W       operand 2
//  out_rd       out  REG_IDX_W   destination
//  out_rd_wen   out  1           destination write flag
//  out_payload  out  PAYLOAD_W   side-band
//  sb_pending   out  REG_COUNT   scoreboard bit vector (bit 0 constant 0)
// BEHAVIOUR
//  - Reset (async, aresetn=0): out_valid=0, out_* data/rd/wen/payload=0, sb_pending=0.
//    Applies immediately mid-operation; in-flight instruction discarded.
//  - wb_hit(r) = wb_en && wb_reg==r && r!=0.
//  - src_busy(r) = r!=0 && sb_pending[r] && !wb_hit(r).
//  - hazard = src_busy(in_rs1) || src_busy(in_rs2)
//             || (in_rd_wen && in_rd!=0 && sb_pending[in_rd] && !wb_hit(in_rd)).
//  - in_ready = (!out_valid || out_ready) && !hazard && !flush. Combinational; in_ready
//    depends on in_valid-free terms only (no in_valid->in_ready path).
//  - Accept = in_valid && in_ready: on posedge load output register, out_valid<=1.
//    Operand mux per source: r==0 -> 0; wb_hit(r) -> wb_data; else rf_rd_data.
//  - No accept: out_ready && out_valid -> out_valid<=0; otherwise output register holds
//    (all out_* stable while out_valid && !out_ready).
//  - Latency: 1 cycle, in accept edge -> out_valid. Full throughput without hazards.
//  - Scoreboard per edge, r!=0: wb_hit(r) clears bit r; accept with in_rd_wen && in_rd==r
//    sets bit r; set wins over a same-cycle clear. Writes to r0 are never tracked.
//  - flush=1: out_valid<=0. If out_valid && out_rd_wen && out_rd!=0, clear
//    sb_pending[out_rd] (flushed write never returns). Flush wins over out_ready and
//    over a same-cycle wb set. Instructions already downstream are unaffected.
//  - wb_en for a register not pending: data written, scoreboard unchanged, no error.
// TESTING
//  1 Reset: aresetn=0 mid-stream with out_valid=1 -> out_valid=0, sb_pending=0 at once.
//  2 r0: rs1=0, rf_rd_data_a=32'hFFFF_FFFF; rd=0, rd_wen=1 -> out_rs1_data=0,
//    sb_pending stays 0.
//  3 RAW: issue rd=5; next rs1=5 -> in_ready=0 until wb_en, wb_reg=5,
//    wb_data=32'h1234_5678; same cycle accept -> out_rs1_data=32'h1234_5678, bit5 cleared.
//  4 WAW: issue rd=7 twice back to back -> 2nd stalls; wb to r7 same cycle as 2nd
//    accept -> sb_pending[7]=1 afterwards.
//  5 Backpressure: out_ready=0 for 3 cycles, in_valid=1 -> in_ready=0, outputs stable;
//    out_ready=1 -> next instruction loaded, no loss or duplication.
//  6 Flush: out_valid=1, out_rd=9, flush=1 -> out_valid=0, sb_pending[9]=0, in_ready=0.

Source files
------------

// File: rtl/operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : operand_fetch_stage
// Purpose : Issue/operand-fetch stage with write scoreboard, writeback bypass
//           and a single valid/ready output register feeding execute.
// Revision: 1.0 - initial release
// ============================================================================
module operand_fetch_stage #(
   parameter int REG_W     = 32,
   parameter int REG_COUNT = 32,
   parameter int PAYLOAD_W = 32,
   localparam int REG_IDX_W = $clog2(REG_COUNT)
) (
   input  logic                 clk,
   input  logic                 aresetn,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [REG_IDX_W-1:0] in_rs1,
   input  logic [REG_IDX_W-1:0] in_rs2,
   input  logic [REG_IDX_W-1:0] in_rd,
   input  logic                 in_rd_wen,
   input  logic [PAYLOAD_W-1:0] in_payload,
   output logic [REG_IDX_W-1:0] rf_rd_reg_a,
   output logic [REG_IDX_W-1:0] rf_rd_reg_b,
   input  logic [REG_W-1:0]     rf_rd_data_a,
   input  logic [REG_W-1:0]     rf_rd_data_b,
   input  logic                 wb_en,
   input  logic [REG_IDX_W-1:0] wb_reg,
   input  logic [REG_W-1:0]     wb_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [REG_W-1:0]     out_rs1_data,
   output logic [REG_W-1:0]     out_rs2_data,
   output logic [REG_IDX_W-1:0] out_rd,
   output logic                 out_rd_wen,
   output logic [PAYLOAD_W-1:0] out_payload,
   output logic [REG_COUNT-1:0] sb_pending
);

   logic                 r_out_valid;
   logic [REG_W-1:0]     r_out_rs1_data;
   logic [REG_W-1:0]     r_out_rs2_data;
   logic [REG_IDX_W-1:0] r_out_rd;
   logic                 r_out_rd_wen;
   logic [PAYLOAD_W-1:0] r_out_payload;
   logic [REG_COUNT-1:0] r_sb;

   logic                 w_hit_a, w_hit_b, w_hit_d;
   logic                 w_busy_a, w_busy_b, w_busy_d;
   logic                 w_hazard, w_ready, w_accept;
   logic [REG_W-1:0]     w_op_a, w_op_b;
   logic [REG_COUNT-1:0] w_sb_next;

   assign rf_rd_reg_a = in_rs1;
   assign rf_rd_reg_b = in_rs2;

   // Writeback to a register this cycle resolves its pending state immediately.
   assign w_hit_a  = wb_en && (wb_reg == in_rs1) && (in_rs1 != '0);
   assign w_hit_b  = wb_en && (wb_reg == in_rs2) && (in_rs2 != '0);
   assign w_hit_d  = wb_en && (wb_reg == in_rd)  && (in_rd  != '0);
   assign w_busy_a = (in_rs1 != '0) && r_sb[in_rs1] && !w_hit_a;
   assign w_busy_b = (in_rs2 != '0) && r_sb[in_rs2] && !w_hit_b;
   assign w_busy_d = in_rd_wen && (in_rd != '0) && r_sb[in_rd] && !w_hit_d;
   assign w_hazard = w_busy_a || w_busy_b || w_busy_d;

   assign w_ready  = (!r_out_valid || out_ready) && !w_hazard && !flush;
   assign w_accept = in_valid && w_ready;
   assign in_ready = w_ready;

   always_comb begin
      w_op_a = rf_rd_data_a;
      if (in_rs1 == '0)
         w_op_a = '0;
      else if (w_hit_a)
         w_op_a = wb_data;

      w_op_b = rf_rd_data_b;
      if (in_rs2 == '0)
         w_op_b = '0;
      else if (w_hit_b)
         w_op_b = wb_data;
   end

   // Ordering encodes priority: writeback clear, then issue set, then flush clear.
   always_comb begin
      w_sb_next = r_sb;
      if (wb_en && (wb_reg != '0))
         w_sb_next[wb_reg] = 1'b0;
      if (w_accept && in_rd_wen && (in_rd != '0))
         w_sb_next[in_rd] = 1'b1;
      if (flush && r_out_valid && r_out_rd_wen && (r_out_rd != '0))
         w_sb_next[r_out_rd] = 1'b0;
      w_sb_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_out_valid    <= 1'b0;
         r_out_rs1_data <= '0;
         r_out_rs2_data <= '0;
         r_out_rd       <= '0;
         r_out_rd_wen   <= 1'b0;
         r_out_payload  <= '0;
         r_sb           <= '0;
      end else begin
         r_sb <= w_sb_next;
         if (flush) begin
            r_out_valid <= 1'b0;
         end else if (w_accept) begin
            r_out_valid    <= 1'b1;
            r_out_rs1_data <= w_op_a;
            r_out_rs2_data <= w_op_b;
            r_out_rd       <= in_rd;
            r_out_rd_wen   <= in_rd_wen;
            r_out_payload  <= in_payload;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid    = r_out_valid;
   assign out_rs1_data = r_out_rs1_data;
   assign out_rs2_data = r_out_rs2_data;
   assign out_rd       = r_out_rd;
   assign out_rd_wen   = r_out_rd_wen;
   assign out_payload  = r_out_payload;
   assign sb_pending   = r_sb;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_operand_fetch_stage
// Purpose : Directed vector table plus hand sequences for operand_fetch_stage.
// Revision: 1.0 - initial release
// ============================================================================
module tb_operand_fetch_stage;

   logic        clk = 1'b0;
   logic        aresetn, flush, in_valid, in_ready, in_rd_wen;
   logic [4:0]  in_rs1, in_rs2, in_rd, rf_rd_reg_a, rf_rd_reg_b, wb_reg, out_rd;
   logic [31:0] in_payload, rf_rd_data_a, rf_rd_data_b, wb_data;
   logic        wb_en, out_valid, out_ready, out_rd_wen;
   logic [31:0] out_rs1_data, out_rs2_data, out_payload, sb_pending;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   operand_fetch_stage dut (
      .clk(clk), .aresetn(aresetn), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
      .in_payload(in_payload),
      .rf_rd_reg_a(rf_rd_reg_a), .rf_rd_reg_b(rf_rd_reg_b),
      .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b),
      .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
      .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_payload(out_payload),
      .sb_pending(sb_pending)
   );

   typedef struct packed {
      logic [4:0]  rs1, rs2, rd;
      logic        wen;
      logic [31:0] rf_a, rf_b;
      logic        wbe;
      logic [4:0]  wbr;
      logic [31:0] wbd, pay;
      logic        e_ready, e_valid;
      logic [31:0] e_op1, e_op2, e_pay, e_sb;
   } vec_t;

   vec_t vec [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic wen, input logic [31:0] pay);
      in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_wen = wen;
      in_payload = pay;
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //        rs1   rs2   rd    wen  rf_a          rf_b          wbe  wbr   wbd           pay  rdy val op1           op2           epay e_sb
      vec[0] = '{5'd0, 5'd3, 5'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0033, 1'b0, 5'd0, 32'h0,       32'd100, 1'b1, 1'b1, 32'h0,       32'h33,      32'd100, 32'h0};
      vec[1] = '{5'd1, 5'd2, 5'd5, 1'b1, 32'h11,        32'h22,        1'b0, 5'd0, 32'h0,       32'd101, 1'b1, 1'b1, 32'h11,      32'h22,      32'd101, 32'h20};
      vec[2] = '{5'd5, 5'd0, 5'd6, 1'b0, 32'hAA,        32'hBB,        1'b0, 5'd0, 32'h0,       32'd102, 1'b0, 1'b0, 32'h11,      32'h22,      32'd101, 32'h20};
      vec[3] = '{5'd5, 5'd0, 5'd6, 1'b0, 32'hAA,        32'hBB,        1'b1, 5'd5, 32'h1234_5678, 32'd103, 1'b1, 1'b1, 32'h1234_5678, 32'h0,     32'd103, 32'h0};
      vec[4] = '{5'd4, 5'd4, 5'd7, 1'b1, 32'h44,        32'h44,        1'b1, 5'd4, 32'hDEAD_BEEF, 32'd104, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd104, 32'h80};
      vec[5] = '{5'd1, 5'd2, 5'd7, 1'b1, 32'h1,         32'h2,         1'b0, 5'd0, 32'h0,       32'd105, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd104, 32'h80};
      vec[6] = '{5'd1, 5'd2, 5'd7, 1'b1, 32'h1,         32'h2,         1'b1, 5'd7, 32'h77,      32'd106, 1'b1, 1'b1, 32'h1,       32'h2,       32'd106, 32'h80};
      vec[7] = '{5'd7, 5'd3, 5'd0, 1'b0, 32'h0,         32'h3,         1'b1, 5'd7, 32'h99,      32'd107, 1'b1, 1'b1, 32'h99,      32'h3,       32'd107, 32'h0};
      vec[8] = '{5'd0, 5'd0, 5'd3, 1'b0, 32'h5,         32'h6,         1'b1, 5'd0, 32'h55,      32'd108, 1'b1, 1'b1, 32'h0,       32'h0,       32'd108, 32'h0};

      aresetn = 1'b0; flush = 1'b0; out_ready = 1'b1;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
      rf_rd_data_a = '0; rf_rd_data_b = '0; wb_en = 1'b0; wb_reg = '0; wb_data = '0;
      repeat (2) edge_step();
      chk("reset_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_sb", sb_pending, 32'd0);
      chk("reset_payload", out_payload, 32'd0);
      aresetn = 1'b1;

      for (int i = 0; i < 9; i++) begin
         drive(1'b1, vec[i].rs1, vec[i].rs2, vec[i].rd, vec[i].wen, vec[i].pay);
         rf_rd_data_a = vec[i].rf_a; rf_rd_data_b = vec[i].rf_b;
         wb_en = vec[i].wbe; wb_reg = vec[i].wbr; wb_data = vec[i].wbd;
         #1;
         chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vec[i].e_ready});
         chk($sformatf("v%0d_rf_reg_a", i), {27'd0, rf_rd_reg_a}, {27'd0, vec[i].rs1});
         edge_step();
         chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vec[i].e_valid});
         chk($sformatf("v%0d_op1", i), out_rs1_data, vec[i].e_op1);
         chk($sformatf("v%0d_op2", i), out_rs2_data, vec[i].e_op2);
         chk($sformatf("v%0d_payload", i), out_payload, vec[i].e_pay);
         chk($sformatf("v%0d_sb", i), sb_pending, vec[i].e_sb);
      end
      wb_en = 1'b0;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
      edge_step();
      chk("drain_valid", {31'd0, out_valid}, 32'd0);

      // Backpressure: A held for three cycles while B waits, then B follows once.
      out_ready = 1'b0;
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 32'd150);
      #1;
      chk("bp_first_ready", {31'd0, in_ready}, 32'd1);
      edge_step();
      chk("bp_first_valid", {31'd0, out_valid}, 32'd1);
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 32'd151);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("bp_stall_ready", {31'd0, in_ready}, 32'd0);
         edge_step();
         chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_hold_payload", out_payload, 32'd150);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
      edge_step();
      chk("bp_next_payload", out_payload, 32'd151);
      chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
      edge_step();
      chk("bp_no_dup", {31'd0, out_valid}, 32'd0);

      // Flush kills the rd=9 instruction and releases its scoreboard bit.
      out_ready = 1'b0;
      drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 32'd200);
      edge_step();
      chk("fl_out_rd", {27'd0, out_rd}, 32'd9);
      chk("fl_out_wen", {31'd0, out_rd_wen}, 32'd1);
      chk("fl_sb_set", sb_pending, 32'h200);
      flush = 1'b1;
      drive(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 32'd201);
      #1;
      chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
      edge_step();
      chk("fl_valid", {31'd0, out_valid}, 32'd0);
      chk("fl_sb_clear", sb_pending, 32'd0);
      flush = 1'b0;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
      edge_step();

      // Asynchronous reset between edges while an instruction is held.
      drive(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 32'd300);
      edge_step();
      chk("rs_pre_valid", {31'd0, out_valid}, 32'd1);
      chk("rs_pre_sb", sb_pending, 32'h400);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
      #3;
      aresetn = 1'b0;
      #1;
      chk("rs_async_valid", {31'd0, out_valid}, 32'd0);
      chk("rs_async_sb", sb_pending, 32'd0);
      chk("rs_async_payload", out_payload, 32'd0);
      chk("rs_async_rd", {27'd0, out_rd}, 32'd0);
      @(posedge clk);
      #1;
      aresetn = 1'b1;
      out_ready = 1'b1;
      edge_step();
      chk("rs_after_valid", {31'd0, out_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
